// File: rtl/pci_target_responder.sv
// PCI target: decodes memory read/write to a 64-byte window and serves
// bursts from a 16 x 32-bit register file with configurable initial wait states.
module pci_target_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        FRAME_,
   input  logic        IRDY_,
   input  logic [3:0]  C_BE_,
   input  logic [31:0] AD,
   output logic        DEVSEL_,
   output logic        TRDY_,
   output logic [31:0] ad_o,
   output logic        ad_oe
);

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = 32;
   localparam int unsigned WCW   = 3;
   localparam int unsigned NLANE = DW / 8;
   localparam logic [3:0]  CMD_RD = 4'b0110;
   localparam logic [3:0]  CMD_WR = 4'b0111;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

   typedef enum logic [2:0] {S_IDLE, S_BUSY, S_WAIT, S_DATA, S_TURN} state_t;

   state_t            r_state;
   logic [AW-1:0]     r_idx;
   logic [3:0]        r_cmd;
   logic [WCW-1:0]    r_wcnt;
   logic              r_frame_prev;
   logic              r_devsel_n;
   logic              r_trdy_n;
   logic              r_ad_oe;
   logic [DW-1:0]     r_ad_o;
   logic [DW-1:0]     r_mem [DEPTH];

   state_t            w_state_nx;
   logic [AW-1:0]     w_idx_nx;
   logic [3:0]        w_cmd_nx;
   logic [WCW-1:0]    w_wcnt_nx;
   logic              w_addr_phase;
   logic              w_hit;
   logic              w_abort;
   logic              w_xfer;
   logic              w_rd_nx;
   logic [DW-1:0]     w_ad_o_nx;

   // Next-state logic; outputs are derived from the next state so they register in step with it.
   always_comb begin
      w_state_nx   = r_state;
      w_idx_nx     = r_idx;
      w_cmd_nx     = r_cmd;
      w_wcnt_nx    = r_wcnt;
      w_xfer       = 1'b0;
      w_addr_phase = (r_state == S_IDLE) && !FRAME_ && r_frame_prev;
      w_hit        = (AD[31:6] == BASE_ADDR[31:6]) && ((C_BE_ == CMD_RD) || (C_BE_ == CMD_WR));
      w_abort      = FRAME_ && IRDY_;

      case (r_state)
         S_IDLE: begin
            if (w_addr_phase) begin
               w_cmd_nx  = C_BE_;
               w_idx_nx  = AD[5:2];
               w_wcnt_nx = '0;
               if (!w_hit)                w_state_nx = S_BUSY;
               else if (WAIT_STATES == 0) w_state_nx = S_DATA;
               else                       w_state_nx = S_WAIT;
            end
         end
         S_BUSY: begin
            if (w_abort) w_state_nx = S_IDLE;
         end
         S_WAIT: begin
            if (w_abort)                  w_state_nx = S_TURN;
            else if (r_wcnt == WAIT_LAST) w_state_nx = S_DATA;
            else                          w_wcnt_nx  = r_wcnt + WCW'(1);
         end
         S_DATA: begin
            if (w_abort) begin
               w_state_nx = S_TURN;
            end else if (!IRDY_) begin
               w_xfer   = 1'b1;
               w_idx_nx = r_idx + AW'(1);
               if (FRAME_) w_state_nx = S_TURN;
            end
         end
         S_TURN:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase

      w_rd_nx   = (w_state_nx == S_DATA) && (w_cmd_nx == CMD_RD);
      w_ad_o_nx = w_rd_nx ? r_mem[w_idx_nx] : r_ad_o;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_cmd        <= '0;
         r_wcnt       <= '0;
         r_frame_prev <= 1'b1;
         r_devsel_n   <= 1'b1;
         r_trdy_n     <= 1'b1;
         r_ad_oe      <= 1'b0;
         r_ad_o       <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_state      <= w_state_nx;
         r_idx        <= w_idx_nx;
         r_cmd        <= w_cmd_nx;
         r_wcnt       <= w_wcnt_nx;
         r_frame_prev <= FRAME_;
         r_devsel_n   <= !((w_state_nx == S_WAIT) || (w_state_nx == S_DATA));
         r_trdy_n     <= (w_state_nx != S_DATA);
         r_ad_oe      <= w_rd_nx;
         r_ad_o       <= w_ad_o_nx;
         // Byte-lane write on a completed write data phase
         if (w_xfer && (r_cmd == CMD_WR)) begin
            for (int unsigned b = 0; b < NLANE; b++) begin
               if (!C_BE_[b]) r_mem[r_idx][8*b +: 8] <= AD[8*b +: 8];
            end
         end
      end
   end

   assign DEVSEL_ = r_devsel_n;
   assign TRDY_   = r_trdy_n;
   assign ad_oe   = r_ad_oe;
   assign ad_o    = r_ad_o;

endmodule

// File: tb/tb_pci_target_responder.sv
// Directed bench for pci_target_responder: vector table for single-phase
// transactions plus hand sequences for bursts, misses, aborts and reset.
module tb_pci_target_responder;

   localparam logic [3:0] CMD_RD = 4'b0110;
   localparam logic [3:0] CMD_WR = 4'b0111;
   // {DEVSEL_, TRDY_, ad_oe}
   localparam logic [2:0] C_IDLE = 3'b110;
   localparam logic [2:0] C_SEL  = 3'b010;
   localparam logic [2:0] C_RD   = 3'b001;
   localparam logic [2:0] C_WR   = 3'b000;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_n;
   logic        irdy_n;
   logic [3:0]  cbe_n;
   logic [31:0] ad;
   logic        devsel_n;
   logic        trdy_n;
   logic [31:0] ad_o;
   logic        ad_oe;

   int nchecks = 0;
   int nerr    = 0;

   typedef struct {
      logic        f;
      logic        i;
      logic [3:0]  be;
      logic [31:0] ad;
      logic [2:0]  exp_ctl;
      logic        chk_d;
      logic [31:0] exp_d;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] exp_d[$];

   pci_target_responder #(.BASE_ADDR(32'h0000_1000), .WAIT_STATES(2)) dut (
      .clk(clk), .reset(reset), .FRAME_(frame_n), .IRDY_(irdy_n), .C_BE_(cbe_n), .AD(ad),
      .DEVSEL_(devsel_n), .TRDY_(trdy_n), .ad_o(ad_o), .ad_oe(ad_oe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic chk_ctl(input string name, input logic [2:0] exp);
      chk(name, 32'({devsel_n, trdy_n, ad_oe}), 32'(exp));
   endtask

   task automatic step(input logic f, input logic i, input logic [3:0] be, input logic [31:0] a);
      frame_n = f; irdy_n = i; cbe_n = be; ad = a;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic f, input logic i, input logic [3:0] be, input logic [31:0] a,
                      input logic [2:0] c, input logic cd, input logic [31:0] d);
      vec_t v;
      v.f = f; v.i = i; v.be = be; v.ad = a; v.exp_ctl = c; v.chk_d = cd; v.exp_d = d;
      vecs.push_back(v);
   endtask

   task automatic add_wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      add(1'b0, 1'b1, CMD_WR, a, C_SEL, 1'b0, '0);
      add(1'b1, 1'b0, be, d, C_SEL, 1'b0, '0);
      add(1'b1, 1'b0, be, d, C_WR, 1'b0, '0);
      add(1'b1, 1'b0, be, d, C_IDLE, 1'b0, '0);
      add(1'b1, 1'b1, 4'hF, '0, C_IDLE, 1'b0, '0);
      add(1'b1, 1'b1, 4'hF, '0, C_IDLE, 1'b0, '0);
   endtask

   task automatic add_rd1(input logic [31:0] a, input logic [31:0] d);
      add(1'b0, 1'b1, CMD_RD, a, C_SEL, 1'b0, '0);
      add(1'b1, 1'b0, 4'h0, '0, C_SEL, 1'b0, '0);
      add(1'b1, 1'b0, 4'h0, '0, C_RD, 1'b1, d);
      add(1'b1, 1'b0, 4'h0, '0, C_IDLE, 1'b0, '0);
      add(1'b1, 1'b1, 4'hF, '0, C_IDLE, 1'b0, '0);
      add(1'b1, 1'b1, 4'hF, '0, C_IDLE, 1'b0, '0);
   endtask

   task automatic do_wr1(input logic [31:0] a, input logic [31:0] d);
      step(1'b0, 1'b1, CMD_WR, a);
      repeat (3) step(1'b1, 1'b0, 4'h0, d);
      repeat (2) step(1'b1, 1'b1, 4'hF, '0);
   endtask

   // Read burst of n phases checked against exp_d; two IRDY_ stall cycles before phase stall_at.
   task automatic rd_burst(input logic [31:0] a, input int n, input int stall_at, input string tag);
      logic last1;
      last1 = (n == 1);
      step(1'b0, 1'b1, CMD_RD, a);
      chk_ctl({tag, " addr"}, C_SEL);
      step(last1, 1'b0, 4'h0, '0);
      chk_ctl({tag, " wait"}, C_SEL);
      step(last1, 1'b0, 4'h0, '0);
      chk_ctl({tag, " first"}, C_RD);
      chk($sformatf("%s d0", tag), ad_o, exp_d[0]);
      for (int k = 0; k < n; k++) begin
         if (k == stall_at) begin
            repeat (2) begin
               step(1'b0, 1'b1, 4'h0, '0);
               chk_ctl($sformatf("%s stall ctl", tag), C_RD);
               chk($sformatf("%s stall d%0d", tag, k), ad_o, exp_d[k]);
            end
         end
         step(1'(k == n - 1), 1'b0, 4'h0, '0);
         if (k != n - 1) begin
            chk_ctl($sformatf("%s ctl%0d", tag, k + 1), C_RD);
            chk($sformatf("%s d%0d", tag, k + 1), ad_o, exp_d[k + 1]);
         end else begin
            chk_ctl({tag, " turn"}, C_IDLE);
         end
      end
      repeat (2) step(1'b1, 1'b1, 4'hF, '0);
   endtask

   task automatic miss(input logic [31:0] a, input logic [3:0] cmd, input string tag);
      step(1'b0, 1'b1, cmd, a);
      chk_ctl({tag, " addr"}, C_IDLE);
      repeat (3) begin
         step(1'b0, 1'b0, 4'h0, '0);
         chk_ctl({tag, " data"}, C_IDLE);
      end
      step(1'b1, 1'b0, 4'h0, '0);
      chk_ctl({tag, " last"}, C_IDLE);
      step(1'b1, 1'b1, 4'hF, '0);
      chk_ctl({tag, " end"}, C_IDLE);
   endtask

   initial begin
      reset = 1'b1;
      step(1'b1, 1'b1, 4'hF, '0);
      step(1'b1, 1'b1, 4'hF, '0);
      chk_ctl("reset ctl", C_IDLE);
      chk("reset ad_o", ad_o, 32'h0);
      reset = 1'b0;
      step(1'b1, 1'b1, 4'hF, '0);

      // Whole register file reads back zero after reset
      exp_d.delete();
      for (int k = 0; k < 16; k++) exp_d.push_back(32'h0);
      rd_burst(32'h0000_1000, 16, -1, "zero16");

      // Single-phase vectors: write/readback, partial-lane write
      add(1'b1, 1'b1, 4'hF, '0, C_IDLE, 1'b0, '0);
      add_wr1(32'h0000_1008, 32'hDEADBEEF, 4'b0000);
      add_rd1(32'h0000_1008, 32'hDEADBEEF);
      add_wr1(32'h0000_100C, 32'h11223344, 4'b0000);
      add_rd1(32'h0000_100C, 32'h11223344);
      add_wr1(32'h0000_100C, 32'hAABBCCDD, 4'b1010);
      add_rd1(32'h0000_100C, 32'h11BB33DD);
      for (int v = 0; v < vecs.size(); v++) begin
         step(vecs[v].f, vecs[v].i, vecs[v].be, vecs[v].ad);
         chk_ctl($sformatf("vec%0d ctl", v), vecs[v].exp_ctl);
         if (vecs[v].chk_d) chk($sformatf("vec%0d data", v), ad_o, vecs[v].exp_d);
      end

      // Wrapping burst 14,15,0,1 with a two-cycle stall
      do_wr1(32'h0000_1038, 32'hE000_000E);
      do_wr1(32'h0000_103C, 32'hF000_000F);
      do_wr1(32'h0000_1000, 32'h0000_A000);
      do_wr1(32'h0000_1004, 32'h1111_0001);
      exp_d.delete();
      exp_d.push_back(32'hE000_000E);
      exp_d.push_back(32'hF000_000F);
      exp_d.push_back(32'h0000_A000);
      exp_d.push_back(32'h1111_0001);
      rd_burst(32'h0000_1038, 4, 1, "wrap");

      // Misses stay silent and return to IDLE
      miss(32'h0000_2000, CMD_RD, "miss_addr");
      miss(32'h0000_1000, 4'b0010, "miss_io");
      exp_d.delete();
      exp_d.push_back(32'hDEADBEEF);
      rd_burst(32'h0000_1008, 1, -1, "post_miss");

      // Master abort in WAIT leaves memory untouched
      step(1'b0, 1'b1, CMD_WR, 32'h0000_1008);
      chk_ctl("abort addr", C_SEL);
      step(1'b1, 1'b1, 4'h0, 32'h1234_5678);
      chk_ctl("abort turn", C_IDLE);
      step(1'b1, 1'b1, 4'hF, '0);
      chk_ctl("abort idle", C_IDLE);
      step(1'b1, 1'b1, 4'hF, '0);
      rd_burst(32'h0000_1008, 1, -1, "post_abort");

      // Reset mid-burst
      step(1'b0, 1'b1, CMD_RD, 32'h0000_1000);
      step(1'b0, 1'b0, 4'h0, '0);
      step(1'b0, 1'b0, 4'h0, '0);
      chk_ctl("rst_burst data", C_RD);
      chk("rst_burst d0", ad_o, 32'h0000_A000);
      step(1'b0, 1'b0, 4'h0, '0);
      chk("rst_burst d1", ad_o, 32'h1111_0001);
      reset = 1'b1;
      step(1'b0, 1'b0, 4'h0, '0);
      chk_ctl("midreset ctl", C_IDLE);
      chk("midreset ad_o", ad_o, 32'h0);
      reset = 1'b0;
      step(1'b1, 1'b1, 4'hF, '0);
      chk_ctl("after reset ctl", C_IDLE);
      exp_d.delete();
      exp_d.push_back(32'h0);
      rd_burst(32'h0000_1038, 1, -1, "post_reset");

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
